pill_fill_ctrl: RTL and testbench
=================================

# pill_fill_ctrl

Parametrised successor to the fixed 3-digit/2-digit bottling controller. It is a complete fill-sequencing controller that counts pills per bottle and bottles per batch in BCD of configurable digit width. It provides cursor-based target entry, 1 s-tick hopper-starvation and bottle-switch timers, latched error cause with operator acknowledge, and emergency stop. It sits between the debounced front-panel switches and sensor inputs and the 7-segment/buzzer output stage, which consume its BCD, cursor and beep-mode outputs.

## Interface
- PILL_DIGITS, 3, BCD digits of the pills-per-bottle target and count (1..4)
- BOTTLE_DIGITS, 2, BCD digits of the bottles-per-batch target and count (1..3)
- TICK_DIV, 1000, clk_1khz cycles per timer tick (nominal 1 s)
- HOPPER_SEC, 5, ticks without a pill before a starvation error (1..15)
- SWITCH_SEC, 2, ticks allowed for a bottle change (1..15)
- clk_1khz  in  1  sole clock, rising edge
- switch_clr  in  1  asynchronous active-low reset
- btn_next  in  1  level; rising edge advances the cursor
- btn_inc  in  1  level; rising edge increments the digit under the cursor
- btn_start  in  1  level; rising edge starts a batch or acknowledges DONE/ERROR/FATAL
- emergency_stop  in  1  level, active-high
- hopper_pulse  in  1  level; each rising edge = one pill dropped
- conveyor_ok  in  1  high = conveyor running
- state  out  3  0 SETTING, 1 RUNNING, 2 SWITCHING, 3 DONE, 4 ERROR, 5 FATAL
- cursor  out  3  edited digit index, 0..PILL_DIGITS+BOTTLE_DIGITS-1
- disp_bcd  out  4*(PILL_DIGITS+BOTTLE_DIGITS)  digit i at [4i+3:4i]; pill digits low (units first), bottle digits above; targets in SETTING, live counts otherwise
- err_cause  out  2  0 none, 1 hopper starvation, 2 conveyor stopped
- beep_mode  out  2  0 off, 1 continuous (DONE), 2 2 Hz (ERROR), 3 4 Hz (FATAL)
- fill_done  out  1  one-cycle pulse per completed bottle

## Operation
- Edge detection: each of btn_next, btn_inc, btn_start and hopper_pulse has a one-flop previous-sample register. An edge is current=1 and previous=0.
- SETTING:
  - btn_next: cursor wraps N-1→0.
  - btn_inc: the selected digit wraps 9→0.
  - btn_start: if pill target and bottle target are both nonzero, go to RUNNING. On entry, clear the pill and bottle counts and load the hopper timer. Otherwise stay in SETTING.
- RUNNING:
  - Each hopper edge BCD-increments the pill count and reloads the hopper timer.
  - When the incremented count equals the pill target: pulse fill_done, increment the bottle count, and clear the pill count.
  - If the new bottle count equals the bottle target, go to DONE. Otherwise go to SWITCHING and load the switch timer.
  - If the hopper timer reaches 0, go to ERROR with err_cause=1.
- SWITCHING:
  - Hopper edges are ignored.
  - When the switch timer reaches 0: if conveyor_ok=1, go to RUNNING and load the hopper timer; else go to ERROR with err_cause=2.
- ERROR:
  - Counts are held and hopper edges are ignored.
  - btn_start returns to RUNNING, loads the hopper timer and clears err_cause. This requires conveyor_ok=1 when err_cause=2; otherwise the press is ignored.
- DONE: btn_start goes to SETTING and clears counts; targets are kept.
- FATAL:
  - Entered from any state, including FATAL itself, while emergency_stop=1.
  - btn_start with emergency_stop=0 goes to SETTING, clears counts and err_cause, and keeps targets.
- Timers:
  - One shared tick prescaler, 0..TICK_DIV-1. A tick fires on wrap.
  - The prescaler is restarted on every timer load.
  - The active timer decrements on each tick and saturates at 0.
- Priority within one cycle:
  1. emergency_stop, then
  2. pill edge over hopper timeout, then
  3. timer load over tick decrement.
- btn_next and btn_inc in the same cycle: increment the digit at the old cursor, then advance.
- Targets change only in SETTING and only via btn_inc.

## Timing
- Reset (switch_clr=0, async): state=0, cursor=0, all targets/counts/disp_bcd=0, err_cause=0, beep_mode=0, fill_done=0, timers and prescaler 0, edge registers 0.
- All outputs are registered or decoded from registers only; no combinational input→output path.
- Input edge sampled at rising edge n: the effect is visible after edge n.
- emergency_stop sampled high at edge n: state=5 after edge n.
- Hopper timeout: exactly HOPPER_SEC*TICK_DIV cycles after the last load with no pill edge.
- Switch duration: exactly SWITCH_SEC*TICK_DIV cycles.
- fill_done is high for the single cycle after the completing edge; the state change happens at the same edge.
- Reset asserted mid-batch returns immediately to the reset values; the targets are lost.

## Test plan
- Defaults, TICK_DIV=4. Enter target pills=003, bottles=02 via next/inc. Start, give 3 hopper edges → fill_done pulse, state=2, disp pills=000 bottles=01. After 8 cycles with conveyor_ok=1 → state=1. Give 3 edges → state=3, beep_mode=1.
- Entry wrap: 10 btn_inc at cursor 0 → digit 0 = 0. 5 btn_next → cursor=0. Start with pill target 000 → state stays 0.
- RUNNING with no pills for 20 cycles (HOPPER_SEC=5, TICK_DIV=4) → state=4, err_cause=1, beep_mode=2. btn_start → state=1, err_cause=0, counts unchanged.
- conveyor_ok=0 at switch expiry → state=4, err_cause=2. btn_start with conveyor_ok=0 → still 4. With conveyor_ok=1 → state=1.
- emergency_stop mid-SWITCHING → state=5, beep_mode=3. btn_start while stop is held → stays 5. Release stop, btn_start → state=0, targets intact, counts 0.
- Pill edge on the same cycle the hopper timer would expire → count increments, no ERROR. switch_clr pulse mid-RUNNING → all outputs 0 immediately.

Source files
------------

// File: rtl/pill_fill_ctrl.sv
// pill_fill_ctrl: BCD pill/bottle fill sequencer with cursor target entry,
// tick-based hopper/switch timers, latched error cause and emergency stop.
module pill_fill_ctrl #(
  parameter int PILL_DIGITS   = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int TICK_DIV      = 1000,
  parameter int HOPPER_SEC    = 5,
  parameter int SWITCH_SEC    = 2
) (
  input  logic clk_1khz,
  input  logic switch_clr,
  input  logic btn_next,
  input  logic btn_inc,
  input  logic btn_start,
  input  logic emergency_stop,
  input  logic hopper_pulse,
  input  logic conveyor_ok,
  output logic [2:0] state,
  output logic [2:0] cursor,
  output logic [4*(PILL_DIGITS+BOTTLE_DIGITS)-1:0] disp_bcd,
  output logic [1:0] err_cause,
  output logic [1:0] beep_mode,
  output logic fill_done
);

  localparam int PW = 4 * PILL_DIGITS;
  localparam int BW = 4 * BOTTLE_DIGITS;
  localparam int DW = PW + BW;
  localparam int ND = PILL_DIGITS + BOTTLE_DIGITS;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_SET   = 3'd0,
    S_RUN   = 3'd1,
    S_SW    = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4,
    S_FATAL = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cur_q, cur_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [PW-1:0] pcnt_q, pcnt_d, pinc;
  logic [BW-1:0] bcnt_q, bcnt_d, binc;
  logic [1:0]    err_q, err_d;
  logic          fd_q, fd_d;
  logic [3:0]    tmr_q, tmr_d, tmr_dec;
  logic [CW-1:0] pre_q, pre_d;
  logic [3:0]    prv_q, cur_in;
  logic          e_start, e_inc, e_next, e_hop;
  logic          tick, expire, ld;

  // {start, inc, next, hopper}
  assign cur_in = {btn_start, btn_inc, btn_next, hopper_pulse};
  assign {e_start, e_inc, e_next, e_hop} = cur_in & ~prv_q;

  assign tick    = (pre_q == CW'(TICK_DIV - 1));
  assign tmr_dec = (tick && tmr_q != 4'd0) ? tmr_q - 4'd1 : tmr_q;
  assign expire  = tick && (tmr_dec == 4'd0);
  assign pre_d   = (ld || tick) ? '0 : pre_q + CW'(1);

  always_comb begin
    logic c;
    c    = 1'b1;
    pinc = pcnt_q;
    for (int i = 0; i < PILL_DIGITS; i++) begin
      if (c) begin
        if (pcnt_q[4*i +: 4] == 4'd9) begin
          pinc[4*i +: 4] = 4'd0;
        end else begin
          pinc[4*i +: 4] = pcnt_q[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic c;
    c    = 1'b1;
    binc = bcnt_q;
    for (int i = 0; i < BOTTLE_DIGITS; i++) begin
      if (c) begin
        if (bcnt_q[4*i +: 4] == 4'd9) begin
          binc[4*i +: 4] = 4'd0;
        end else begin
          binc[4*i +: 4] = bcnt_q[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    fd_d    = 1'b0;
    tmr_d   = tmr_dec;
    ld      = 1'b0;
    if (emergency_stop) begin
      state_d = S_FATAL;
    end else begin
      unique case (state_q)
        S_SET: begin
          for (int i = 0; i < ND; i++) begin
            if (e_inc && cur_q == 3'(i)) begin
              tgt_d[4*i +: 4] = (tgt_q[4*i +: 4] == 4'd9) ?
                                4'd0 : tgt_q[4*i +: 4] + 4'd1;
            end
          end
          if (e_next) begin
            cur_d = (cur_q == 3'(ND - 1)) ? 3'd0 : cur_q + 3'd1;
          end
          if (e_start && tgt_d[PW-1:0] != '0 &&
              tgt_d[DW-1:PW] != '0) begin
            state_d = S_RUN;
            pcnt_d  = '0;
            bcnt_d  = '0;
            tmr_d   = 4'(HOPPER_SEC);
            ld      = 1'b1;
          end
        end
        S_RUN: begin
          // a pill edge always beats a simultaneous timeout
          if (e_hop) begin
            if (pinc == tgt_q[PW-1:0]) begin
              fd_d   = 1'b1;
              pcnt_d = '0;
              bcnt_d = binc;
              if (binc == tgt_q[DW-1:PW]) begin
                state_d = S_DONE;
              end else begin
                state_d = S_SW;
                tmr_d   = 4'(SWITCH_SEC);
                ld      = 1'b1;
              end
            end else begin
              pcnt_d = pinc;
              tmr_d  = 4'(HOPPER_SEC);
              ld     = 1'b1;
            end
          end else if (expire) begin
            state_d = S_ERR;
            err_d   = 2'd1;
          end
        end
        S_SW: begin
          if (expire) begin
            if (conveyor_ok) begin
              state_d = S_RUN;
              tmr_d   = 4'(HOPPER_SEC);
              ld      = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 2'd2;
            end
          end
        end
        S_DONE: begin
          if (e_start) begin
            state_d = S_SET;
            pcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
        S_ERR: begin
          if (e_start && (err_q != 2'd2 || conveyor_ok)) begin
            state_d = S_RUN;
            err_d   = 2'd0;
            tmr_d   = 4'(HOPPER_SEC);
            ld      = 1'b1;
          end
        end
        S_FATAL: begin
          if (e_start) begin
            state_d = S_SET;
            pcnt_d  = '0;
            bcnt_d  = '0;
            err_d   = 2'd0;
          end
        end
        default: state_d = S_SET;
      endcase
    end
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_q <= S_SET;
      cur_q   <= 3'd0;
      tgt_q   <= '0;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= 2'd0;
      fd_q    <= 1'b0;
      tmr_q   <= 4'd0;
      pre_q   <= '0;
      prv_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      fd_q    <= fd_d;
      tmr_q   <= tmr_d;
      pre_q   <= pre_d;
      prv_q   <= cur_in;
    end
  end

  assign state     = state_q;
  assign cursor    = cur_q;
  assign err_cause = err_q;
  assign fill_done = fd_q;
  assign disp_bcd  = (state_q == S_SET) ? tgt_q : {bcnt_q, pcnt_q};

  always_comb begin
    beep_mode = 2'd0;
    case (state_q)
      S_DONE:  beep_mode = 2'd1;
      S_ERR:   beep_mode = 2'd2;
      S_FATAL: beep_mode = 2'd3;
      default: beep_mode = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pill_fill_ctrl.sv
// tb_pill_fill_ctrl: directed plus randomized stimulus against a
// cycle-count/integer reference model of the fill controller.
module tb_pill_fill_ctrl;

  localparam int TD = 4;
  localparam int HS = 5;
  localparam int SS = 2;
  localparam int NEXT = 0, INC = 1, START = 2, HOP = 3;

  logic clk_1khz, switch_clr;
  logic btn_next, btn_inc, btn_start, emergency_stop;
  logic hopper_pulse, conveyor_ok;
  logic [2:0] state, cursor;
  logic [19:0] disp_bcd;
  logic [1:0] err_cause, beep_mode;
  logic fill_done;

  int checks = 0;
  int failures = 0;

  int m_st, m_cur, m_pc, m_bc, m_err, m_fd, m_left;
  int m_tgt[5];
  bit p_next, p_inc, p_start, p_hop;

  pill_fill_ctrl #(
    .PILL_DIGITS(3), .BOTTLE_DIGITS(2), .TICK_DIV(TD),
    .HOPPER_SEC(HS), .SWITCH_SEC(SS)
  ) dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr),
    .btn_next(btn_next), .btn_inc(btn_inc), .btn_start(btn_start),
    .emergency_stop(emergency_stop), .hopper_pulse(hopper_pulse),
    .conveyor_ok(conveyor_ok), .state(state), .cursor(cursor),
    .disp_bcd(disp_bcd), .err_cause(err_cause),
    .beep_mode(beep_mode), .fill_done(fill_done)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ptgt();
    return m_tgt[0] + 10 * m_tgt[1] + 100 * m_tgt[2];
  endfunction

  function automatic int btgt();
    return m_tgt[3] + 10 * m_tgt[4];
  endfunction

  function automatic logic [31:0] bcd3(input int v);
    logic [31:0] r;
    r = '0;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic logic [31:0] exp_disp();
    logic [31:0] r;
    r = '0;
    if (m_st == 0) begin
      for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'(m_tgt[i]);
    end else begin
      r = bcd3(m_pc) | (bcd3(m_bc) << 12);
    end
    return r;
  endfunction

  function automatic int exp_beep();
    if (m_st == 3) return 1;
    if (m_st == 4) return 2;
    if (m_st == 5) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cur = 0; m_pc = 0; m_bc = 0;
    m_err = 0; m_fd = 0; m_left = 0;
    for (int i = 0; i < 5; i++) m_tgt[i] = 0;
    p_next = 0; p_inc = 0; p_start = 0; p_hop = 0;
  endtask

  task automatic model_edge();
    bit en, ei, es, eh;
    en = btn_next && !p_next;
    ei = btn_inc && !p_inc;
    es = btn_start && !p_start;
    eh = hopper_pulse && !p_hop;
    m_fd = 0;
    if (emergency_stop) begin
      m_st = 5;
    end else begin
      case (m_st)
        0: begin
          if (ei) m_tgt[m_cur] = (m_tgt[m_cur] + 1) % 10;
          if (en) m_cur = (m_cur + 1) % 5;
          if (es && ptgt() != 0 && btgt() != 0) begin
            m_st = 1; m_pc = 0; m_bc = 0; m_left = HS * TD;
          end
        end
        1: begin
          if (eh) begin
            m_pc++;
            if (m_pc == ptgt()) begin
              m_fd = 1; m_pc = 0; m_bc++;
              if (m_bc == btgt()) m_st = 3;
              else begin m_st = 2; m_left = SS * TD; end
            end else begin
              m_left = HS * TD;
            end
          end else begin
            m_left--;
            if (m_left == 0) begin m_st = 4; m_err = 1; end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            if (conveyor_ok) begin m_st = 1; m_left = HS * TD; end
            else begin m_st = 4; m_err = 2; end
          end
        end
        3: if (es) begin m_st = 0; m_pc = 0; m_bc = 0; end
        4: if (es && (m_err != 2 || conveyor_ok)) begin
             m_st = 1; m_err = 0; m_left = HS * TD;
           end
        5: if (es) begin m_st = 0; m_pc = 0; m_bc = 0; m_err = 0; end
        default: m_st = 0;
      endcase
    end
    p_next = btn_next; p_inc = btn_inc;
    p_start = btn_start; p_hop = hopper_pulse;
  endtask

  task automatic cmp_all();
    chk("state", 32'(state), 32'(m_st));
    chk("cursor", 32'(cursor), 32'(m_cur));
    chk("disp", 32'(disp_bcd), exp_disp());
    chk("err_cause", 32'(err_cause), 32'(m_err));
    chk("beep_mode", 32'(beep_mode), 32'(exp_beep()));
    chk("fill_done", 32'(fill_done), 32'(m_fd));
  endtask

  task automatic cyc();
    @(posedge clk_1khz);
    model_edge();
    @(negedge clk_1khz);
    cmp_all();
  endtask

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      NEXT:    btn_next = v;
      INC:     btn_inc = v;
      START:   btn_start = v;
      default: hopper_pulse = v;
    endcase
  endtask

  task automatic pulse(input int sel);
    set_btn(sel, 1'b1);
    cyc();
    set_btn(sel, 1'b0);
    cyc();
  endtask

  initial begin
    switch_clr = 1'b1;
    btn_next = 0; btn_inc = 0; btn_start = 0;
    emergency_stop = 0; hopper_pulse = 0; conveyor_ok = 1;
    model_reset();
    #1 switch_clr = 1'b0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_disp", 32'(disp_bcd), 0);
    chk("rst_err", 32'(err_cause), 0);
    chk("rst_beep", 32'(beep_mode), 0);
    chk("rst_fill", 32'(fill_done), 0);
    @(negedge clk_1khz);
    switch_clr = 1'b1;

    // target entry: pills 003, bottles 02
    repeat (3) pulse(INC);
    repeat (3) pulse(NEXT);
    repeat (2) pulse(INC);
    repeat (2) pulse(NEXT);
    chk("entry_cursor", 32'(cursor), 0);
    chk("entry_disp", 32'(disp_bcd), 32'h02003);

    // first bottle, switch, second bottle
    pulse(START);
    chk("start_run", 32'(state), 1);
    repeat (2) pulse(HOP);
    hopper_pulse = 1; cyc();
    chk("b1_fill", 32'(fill_done), 1);
    chk("b1_state", 32'(state), 2);
    chk("b1_disp", 32'(disp_bcd), 32'h01000);
    hopper_pulse = 0;
    repeat (7) cyc();
    chk("sw_hold", 32'(state), 2);
    cyc();
    chk("sw_end", 32'(state), 1);
    repeat (2) pulse(HOP);
    hopper_pulse = 1; cyc();
    chk("done_state", 32'(state), 3);
    chk("done_beep", 32'(beep_mode), 1);
    hopper_pulse = 0; cyc();
    pulse(START);
    chk("done_ack", 32'(state), 0);
    chk("done_tgt", 32'(disp_bcd), 32'h02003);

    // digit and cursor wrap, zero target refused
    repeat (7) pulse(INC);
    repeat (10) pulse(INC);
    chk("wrap_digit", 32'(disp_bcd[3:0]), 0);
    repeat (5) pulse(NEXT);
    chk("wrap_cursor", 32'(cursor), 0);
    pulse(START);
    chk("zero_tgt", 32'(state), 0);
    repeat (3) pulse(INC);

    // hopper starvation
    pulse(START);
    pulse(HOP);
    repeat (18) cyc();
    chk("hop_pre", 32'(state), 1);
    cyc();
    chk("hop_err", 32'(state), 4);
    chk("hop_cause", 32'(err_cause), 1);
    chk("hop_beep", 32'(beep_mode), 2);
    pulse(START);
    chk("hop_ack", 32'(state), 1);
    chk("hop_ack_err", 32'(err_cause), 0);
    chk("hop_ack_disp", 32'(disp_bcd), 32'h00001);

    // conveyor stopped at switch expiry
    pulse(HOP);
    hopper_pulse = 1; cyc();
    hopper_pulse = 0; conveyor_ok = 0;
    repeat (8) cyc();
    chk("conv_err", 32'(state), 4);
    chk("conv_cause", 32'(err_cause), 2);
    pulse(START);
    chk("conv_block", 32'(state), 4);
    conveyor_ok = 1;
    pulse(START);
    chk("conv_ack", 32'(state), 1);

    // emergency stop during switching
    repeat (2) pulse(HOP);
    hopper_pulse = 1; cyc();
    hopper_pulse = 0; cyc();
    pulse(START);
    pulse(START);
    repeat (2) pulse(HOP);
    hopper_pulse = 1; cyc();
    chk("es_sw", 32'(state), 2);
    hopper_pulse = 0; cyc();
    emergency_stop = 1; cyc();
    chk("es_state", 32'(state), 5);
    chk("es_beep", 32'(beep_mode), 3);
    pulse(START);
    chk("es_held", 32'(state), 5);
    emergency_stop = 0; cyc();
    pulse(START);
    chk("es_ack", 32'(state), 0);
    chk("es_tgt", 32'(disp_bcd), 32'h02003);
    pulse(START);
    chk("es_counts", 32'(disp_bcd), 0);

    // pill edge on the expiry cycle wins
    repeat (18) cyc();
    hopper_pulse = 1; cyc();
    chk("race_state", 32'(state), 1);
    chk("race_disp", 32'(disp_bcd), 32'h00001);

    // asynchronous reset mid-run
    switch_clr = 0; hopper_pulse = 0;
    #1;
    model_reset();
    chk("arst_state", 32'(state), 0);
    chk("arst_disp", 32'(disp_bcd), 0);
    chk("arst_fill", 32'(fill_done), 0);
    @(negedge clk_1khz);
    switch_clr = 1;

    // randomized traffic against the model
    repeat (2) pulse(INC);
    repeat (3) pulse(NEXT);
    repeat (3) pulse(INC);
    repeat (2) pulse(NEXT);
    for (int n = 0; n < 1500; n++) begin
      btn_next = ($urandom % 64) == 0;
      btn_inc = ($urandom % 64) == 0;
      btn_start = ($urandom % 12) == 0;
      hopper_pulse = ((n / 250) % 2 == 0) ? (($urandom % 4) == 0)
                                          : (($urandom % 40) == 0);
      conveyor_ok = ($urandom % 6) != 0;
      emergency_stop = ($urandom % 150) == 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
